// File: rtl/fxp_multiplier.sv
// rtl/fxp_multiplier.sv - sequential signed fixed-point shift-add multiplier
module fxp_multiplier #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] val
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] NEG_MAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] POS_MAX = NEG_MAG - {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               sign_q;
  logic               busy_q, done_q, valid_q, ovf_q;
  logic [WIDTH-1:0]   val_q;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] mag;
  logic               ovf_d;
  logic [WIDTH-1:0]   val_d;

  // Magnitudes fit as unsigned: the most negative operand maps to 2^(WIDTH-1).
  assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  always_comb begin
    mag   = acc_q >> FBITS;
    ovf_d = sign_q ? (mag > NEG_MAG) : (mag > POS_MAX);
    val_d = '0;
    if (!ovf_d) begin
      val_d = sign_q ? (~mag[WIDTH-1:0] + 1'b1) : mag[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      val_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, abs_a};
            mplier_q <= abs_b;
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            val_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= FINAL;
          end
        end
        FINAL: begin
          val_q   <= val_d;
          ovf_q   <= ovf_d;
          valid_q <= ~ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign val   = val_q;

endmodule
